dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 17 +
 rtl/dmem_array.sv | 46 ++++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   DSIZE / ASIZE : default data word width and word-address width
//   CNT_W         : width of the wait-state counter (WAIT_CYCLES up to 15)
//   state_t       : responder FSM encoding
package dmem_responder_pkg;

  localparam int DSIZE = 32;
  localparam int ASIZE = 32;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage for the data-memory responder.
// Ports:
//   clk     : clock, all updates on the rising edge
//   rst     : asynchronous active-low clear of every word and of the read register
//   we      : write enable, wdata is written to mem[waddr]
//   waddr   : write word index
//   wdata   : write data
//   rd_en   : load the read register this edge
//   rd_zero : when loading, load zero instead of mem[raddr]
//   raddr   : read word index
//   rdata   : registered read data, holds between rd_en pulses
module dmem_array #(
  parameter int DSIZE = 32,
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rd_en,
  input  logic             rd_zero,
  input  logic [IDX_W-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rd_zero ? '0 : mem[raddr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the datapath's data-memory interface. Accepts one
// load/store at a time, waits WAIT_CYCLES states, performs the access on an
// internal array and returns data plus an out-of-range error flag.
// Ports:
//   clk        : clock
//   rst        : asynchronous active-low reset
//   req_valid  : request present          req_ready : responder idle, can accept
//   req_write  : 1 = store, 0 = load      req_addr  : word address
//   req_wdata  : store data
//   rsp_valid  : response present         rsp_ready : requester consumes response
//   rsp_rdata  : load data (0 for stores and errors)
//   rsp_err    : address was out of range
//   busy       : transaction in flight (WAIT or RESP)
module dmem_responder #(
  parameter int DSIZE       = dmem_responder_pkg::DSIZE,
  parameter int ASIZE       = dmem_responder_pkg::ASIZE,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [ASIZE-1:0] req_addr,
  input  logic [DSIZE-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DSIZE-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             busy
);

  import dmem_responder_pkg::*;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             enter_resp;

  logic             wr_q;
  logic [ASIZE-1:0] addr_q;
  logic [DSIZE-1:0] wdata_q;

  logic             accept;
  logic             src_write;
  logic [ASIZE-1:0] src_addr;
  logic [DSIZE-1:0] src_wdata;
  logic             in_range;

  assign accept = req_valid && (state_q == IDLE);

  // With zero wait states RESP is entered on the accept edge itself, so the
  // access must use the live request rather than the capture registers.
  assign src_write = (state_q == IDLE) ? req_write : wr_q;
  assign src_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign src_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

  // Full-width compare: high address bits must not alias into the array.
  assign in_range = (64'(src_addr) < 64'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Request capture; requester inputs are not looked at after the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) err_d = !in_range;
  end

  dmem_array #(
    .DSIZE (DSIZE),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (enter_resp && src_write && in_range),
    .waddr   (src_addr[IDX_W-1:0]),
    .wdata   (src_wdata),
    .rd_en   (enter_resp),
    .rd_zero (src_write || !in_range),
    .raddr   (src_addr[IDX_W-1:0]),
    .rdata   (rsp_rdata)
  );

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  // WAIT_CYCLES = 2 instance
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  // WAIT_CYCLES = 0 instance
  logic        z_req_valid = 1'b0;
  logic        z_req_ready;
  logic        z_req_write = 1'b0;
  logic [31:0] z_req_addr  = '0;
  logic [31:0] z_req_wdata = '0;
  logic        z_rsp_valid;
  logic        z_rsp_ready = 1'b1;
  logic [31:0] z_rsp_rdata;
  logic        z_rsp_err;
  logic        z_busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DSIZE(32), .ASIZE(32), .DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.DSIZE(32), .ASIZE(32), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .busy(z_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the WAIT_CYCLES=2 instance with rsp_ready held high.
  task automatic xact(input string tag, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output logic e);
    int n;
    check({tag, "_ready"}, 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      check({tag, "_busy"}, 64'(busy), 64'(1));
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(2));
    rd = rsp_rdata;
    e  = rsp_err;
    tick();
    check({tag, "_done"}, 64'({rsp_valid, busy, req_ready}), 64'(3'b001));
    check({tag, "_hold"}, 64'({rsp_err, rsp_rdata}), 64'({e, rd}));
  endtask

  logic [31:0] rd;
  logic        e;

  initial begin
    // 1. Reset with a request pending
    rst = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd10;
    repeat (3) tick();
    check("rst_outs", 64'({rsp_valid, busy, rsp_err}), 64'(0));
    check("rst_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_z_busy", 64'({z_rsp_valid, z_busy}), 64'(0));
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'(1));
    tick();
    xact("load10", 1'b0, 32'd10, 32'd0, rd, e);
    check("load10_data", 64'({e, rd}), 64'({1'b0, 32'h0}));

    // 2. Store then load
    xact("st5", 1'b1, 32'd5, 32'hDEADBEEF, rd, e);
    check("st5_rsp", 64'({e, rd}), 64'({1'b0, 32'h0}));
    xact("ld5", 1'b0, 32'd5, 32'd0, rd, e);
    check("ld5_rsp", 64'({e, rd}), 64'({1'b0, 32'hDEADBEEF}));

    // 3. Backpressure, with an intruding store that must be ignored
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd5;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 64'({rsp_valid, req_ready}), 64'(2'b10));
      check("bp_rdata", 64'({rsp_err, rsp_rdata}), 64'({1'b0, 32'hDEADBEEF}));
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd5; req_wdata = 32'h1;
      tick();
    end
    req_valid = 1'b0; req_write = 1'b0; req_wdata = '0;
    check("bp_still", 64'({rsp_valid, rsp_rdata}), 64'({1'b1, 32'hDEADBEEF}));
    rsp_ready = 1'b1;
    tick();
    check("bp_release", 64'({rsp_valid, busy, req_ready}), 64'(3'b001));
    xact("bp_reload", 1'b0, 32'd5, 32'd0, rd, e);
    check("bp_reload_data", 64'({e, rd}), 64'({1'b0, 32'hDEADBEEF}));

    // 4. Out of range
    xact("oor_st", 1'b1, 32'd256, 32'h1234, rd, e);
    check("oor_st_rsp", 64'({e, rd}), 64'({1'b1, 32'h0}));
    xact("ld0", 1'b0, 32'd0, 32'd0, rd, e);
    check("ld0_rsp", 64'({e, rd}), 64'({1'b0, 32'h0}));
    xact("ld100", 1'b0, 32'h100, 32'd0, rd, e);
    check("ld100_rsp", 64'({e, rd}), 64'({1'b1, 32'h0}));
    xact("ld_hi", 1'b0, 32'h8000_0005, 32'd0, rd, e);
    check("ld_hi_rsp", 64'({e, rd}), 64'({1'b1, 32'h0}));
    xact("ld255", 1'b0, 32'd255, 32'd0, rd, e);
    check("ld255_rsp", 64'({e, rd}), 64'({1'b0, 32'h0}));

    // 5. Reset during WAIT
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd7; req_wdata = 32'h55;
    tick();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    check("mid_busy", 64'(busy), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("mid_rst_outs", 64'({rsp_valid, busy}), 64'(0));
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_no_rsp", 64'({rsp_valid, busy}), 64'(0));
    end
    xact("ld7", 1'b0, 32'd7, 32'd0, rd, e);
    check("ld7_rsp", 64'({e, rd}), 64'({1'b0, 32'h0}));
    xact("ld5_cleared", 1'b0, 32'd5, 32'd0, rd, e);
    check("ld5_cleared_rsp", 64'({e, rd}), 64'({1'b0, 32'h0}));

    // 6. Zero wait states, back-to-back store/load
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'd3; z_req_wdata = 32'hA5A5A5A5;
    check("z_ready0", 64'(z_req_ready), 64'(1));
    tick();
    check("z_st_rsp", 64'({z_rsp_valid, z_req_ready, z_rsp_err, z_rsp_rdata}),
          64'({1'b1, 1'b0, 1'b0, 32'h0}));
    z_req_write = 1'b0; z_req_wdata = '0;
    tick();
    check("z_gap", 64'({z_rsp_valid, z_req_ready}), 64'(2'b01));
    tick();
    z_req_valid = 1'b0; z_req_addr = '0;
    check("z_ld_rsp", 64'({z_rsp_valid, z_rsp_err, z_rsp_rdata}),
          64'({1'b1, 1'b0, 32'hA5A5A5A5}));
    tick();
    check("z_idle", 64'({z_rsp_valid, z_busy, z_rsp_rdata}), 64'({1'b0, 1'b0, 32'hA5A5A5A5}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
